// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/MEM memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> DONE)
//   grant_t     : which requester owns the in-flight access
//   FAIR_LIMIT  : consecutive DATA grants (with IF waiting) before IF is forced in
//                 (only used when MEM_ARB_FAIR_EN is defined)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_DATA
    } grant_t;

    localparam int FAIR_LIMIT = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port, the memory port
// and the pipeline stall outputs of the arbiter.
//   slave  : arbiter side (consumes requests and mem_rdata, drives everything else)
//   master : pipeline + memory side (drives requests and mem_rdata)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // stalls
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// lat_counter: loadable down-counter with a zero flag, used to time the
// fixed memory read latency.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   dec      : decrement by one, saturating at zero
//   cnt      : current count
//   zero     : cnt == 0
module lat_counter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between the
// IF (fetch) and MEM (load/store) pipeline stages. DATA has priority over IF.
// A grant in IDLE registers the memory command, ACCESS holds mem_en for
// MEM_LAT cycles, DONE pulses the granted ack with the captured read data.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (fetch/data ports, memory port, stalls)
// Optional: define MEM_ARB_FAIR_EN to force an IF grant after FAIR_LIMIT
// consecutive DATA grants made while IF was waiting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_t       state, state_n;
    grant_t           grant;
    logic             gnt_d, gnt_if;
    logic             fair_force;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_zero;
    logic             capture;

`ifdef MEM_ARB_FAIR_EN
    logic [1:0] fair_cnt;

    // Once IF has watched FAIR_LIMIT DATA grants go by, it wins the next one.
    assign fair_force = bus.if_req && (fair_cnt == 2'(FAIR_LIMIT));

    always_ff @(posedge clk) begin
        if (rst)
            fair_cnt <= '0;
        else if (gnt_if)
            fair_cnt <= '0;
        else if (gnt_d && bus.if_req && fair_cnt != 2'(FAIR_LIMIT))
            fair_cnt <= fair_cnt + 1'b1;
    end
`else
    assign fair_force = 1'b0;
`endif

    assign gnt_d   = (state == IDLE) && bus.d_req && !fair_force;
    assign gnt_if  = (state == IDLE) && bus.if_req && !gnt_d;
    assign capture = (state == ACCESS) && lat_zero;

    lat_counter #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (gnt_d || gnt_if),
        .load_val (LAT_INIT),
        .dec      (state == ACCESS),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (gnt_d || gnt_if) state_n = ACCESS;
            ACCESS:  if (lat_zero) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory command and rdata registers; the command is frozen for the
    // whole ACCESS window because it only loads on a grant in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant         <= GNT_NONE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            if (gnt_d) begin
                grant         <= GNT_DATA;
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
            end else if (gnt_if) begin
                grant         <= GNT_IF;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
            end else if (state == DONE) begin
                grant         <= GNT_NONE;
            end
            // Stores capture too; the pipeline ignores d_rdata on a store ack.
            if (capture && grant == GNT_IF)
                bus.if_rdata <= bus.mem_rdata;
            if (capture && grant == GNT_DATA)
                bus.d_rdata  <= bus.mem_rdata;
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.if_ack    = (state == DONE) && (grant == GNT_IF);
    assign bus.d_ack     = (state == DONE) && (grant == GNT_DATA);
    assign bus.stall_if  = bus.if_req && !bus.if_ack;
    assign bus.stall_mem = bus.d_req && !bus.d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// with MEM_LAT=2. The memory model returns {32'hC0DE_0000, cycle count} so the
// expected read data for an access is known from the cycle it is sampled in.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_rdata = {32'hC0DE_0000, cyc};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_rd;
        logic [63:0] addr;
        int          n_if, n_d, seen;

        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_state", dut.state, IDLE);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_acks", {bus.if_ack, bus.d_ack}, 0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);

        // IF read
        tick();
        bus.if_req = 1; bus.if_addr = 64'h100;
        #1;
        chk("if_c0_stall", bus.stall_if, 1);
        chk("if_c0_en", bus.mem_en, 0);
        tick(); #1;
        chk("if_c1_en", bus.mem_en, 1);
        chk("if_c1_addr", bus.mem_addr, 64'h100);
        chk("if_c1_we", bus.mem_we, 0);
        chk("if_c1_stall", bus.stall_if, 1);
        tick(); #1;
        chk("if_c2_en", bus.mem_en, 1);
        chk("if_c2_stall", bus.stall_if, 1);
        exp_rd = {32'hC0DE_0000, cyc};
        tick(); #1;
        chk("if_c3_ack", bus.if_ack, 1);
        chk("if_c3_rdata", bus.if_rdata, exp_rd);
        chk("if_c3_stall", bus.stall_if, 0);
        chk("if_c3_en", bus.mem_en, 0);
        bus.if_req = 0;
        tick(); #1;
        chk("if_c4_ack", bus.if_ack, 0);
        chk("if_c4_hold", bus.if_rdata, exp_rd);

        // Store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h2000; bus.d_wdata = 64'hDEADBEEF;
        #1;
        chk("st_c0_stall", bus.stall_mem, 1);
        tick(); #1;
        chk("st_c1_en", bus.mem_en, 1);
        chk("st_c1_we", bus.mem_we, 1);
        chk("st_c1_addr", bus.mem_addr, 64'h2000);
        chk("st_c1_wdata", bus.mem_wdata, 64'hDEADBEEF);
        tick(); #1;
        chk("st_c2_en_we", {bus.mem_en, bus.mem_we}, 2'b11);
        tick(); #1;
        chk("st_c3_dack", bus.d_ack, 1);
        chk("st_c3_ifack", bus.if_ack, 0);
        chk("st_c3_stall", bus.stall_mem, 0);
        bus.d_req = 0; bus.d_we = 0;
        tick(); #1;
        chk("st_c4_dack", bus.d_ack, 0);

        // Collision: DATA first, IF granted at cycle 4, if_ack at cycle 7
        bus.if_req = 1; bus.if_addr = 64'h300;
        bus.d_req = 1; bus.d_addr = 64'h400;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("col_c%0d_stall_if", k), bus.stall_if, (k <= 6));
            chk($sformatf("col_c%0d_ifack", k), bus.if_ack, (k == 7));
            chk($sformatf("col_c%0d_dack", k), bus.d_ack, (k == 3));
            chk($sformatf("col_c%0d_en", k), bus.mem_en, (k == 1 || k == 2 || k == 5 || k == 6));
            if (k == 1) chk("col_d_addr", bus.mem_addr, 64'h400);
            if (k == 5) chk("col_if_addr", bus.mem_addr, 64'h300);
            if (k == 3) bus.d_req = 0;
            if (k == 7) bus.if_req = 0;
        end

        // Reset during a DATA access
        tick();
        bus.d_req = 1; bus.d_addr = 64'h500;
        tick(); #1;
        chk("rm_c1_en", bus.mem_en, 1);
        tick();
        rst = 1;
        tick();
        rst = 0; bus.d_req = 0;
        #1;
        chk("rm_c3_state", dut.state, IDLE);
        chk("rm_c3_en", bus.mem_en, 0);
        chk("rm_c3_dack", bus.d_ack, 0);
        chk("rm_c3_rdata", bus.d_rdata, 0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | int'(bus.d_ack) | int'(bus.if_ack);
        end
        chk("rm_no_ack", seen, 0);

        // Back-to-back loads, grants every 4 cycles
        addr = 64'h600;
        bus.d_req = 1; bus.d_addr = addr;
        exp_rd = '0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("b2b_c%0d_dack", k), bus.d_ack, (k % 4 == 3));
            if (k % 4 == 1) chk($sformatf("b2b_c%0d_addr", k), bus.mem_addr, addr);
            if (k % 4 == 2) begin
                chk($sformatf("b2b_c%0d_hold", k), bus.d_rdata, exp_rd);
                exp_rd = {32'hC0DE_0000, cyc};
            end
            if (k % 4 == 3) begin
                chk($sformatf("b2b_c%0d_rdata", k), bus.d_rdata, exp_rd);
                addr = addr + 64'h40;
                bus.d_addr = addr;
            end
        end
        bus.d_req = 0;
        tick(); #1;
        chk("b2b_end_hold", bus.d_rdata, exp_rd);

        // Both held continuously for 16 cycles
        bus.d_req = 1; bus.d_addr = 64'h700; bus.if_req = 1; bus.if_addr = 64'h800;
        n_if = 0; n_d = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            #1;
            n_if += int'(bus.if_ack);
            n_d  += int'(bus.d_ack);
        end
        bus.d_req = 0; bus.if_req = 0;
`ifdef MEM_ARB_FAIR_EN
        chk("fair_if_acks", n_if, 1);
        chk("fair_d_acks", n_d, 3);
`else
        chk("prio_if_acks", n_if, 0);
        chk("prio_d_acks", n_d, 4);
`endif
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end expected end before 50000");
        $fatal(1, "timeout");
    end
endmodule
